checkpoint_monitor: RTL and testbench
=====================================

CHECKPOINT_MONITOR -- requirements
Module: checkpoint_monitor

Interface
REQ-001 Parameter DATA_W, default 16, checkpoint word width (12..32).
REQ-002 Parameter PREFIX, default 8'hAB, required value of checkbits[DATA_W-1:8] for a word to be a marker.
REQ-003 Parameter N_TESTS, default 3, number of tests in the sequence (1..15).
REQ-004 Parameter STABLE_CYC, default 2, consecutive cycles a word must hold before acceptance (1..15).
REQ-005 Parameter TIMEOUT_CYC, default 100000, cycles allowed from arming to final end marker.
REQ-006 Parameter CNT_W, default 32, cycle-counter width.
REQ-007 Port clock in 1: sole clock; all state on rising edge.
REQ-008 Port resetb in 1: asynchronous, active-low reset.
REQ-009 Port enable in 1: arms the monitor while high; low returns it to IDLE.
REQ-010 Port checkbits in DATA_W: progress word driven by firmware through GPIO.
REQ-011 Port rd_idx in 4: selects test result for rd_cycles.
REQ-012 Port busy out 1: high in WAIT_START or RUN.
REQ-013 Port pass out 1 / fail out 1: sticky verdicts.
REQ-014 Port fail_code out 2: 0 none, 1 timeout, 2 order error.
REQ-015 Port cur_test out 4: index of test being waited on or run.
REQ-016 Port start_pulse out 1 / end_pulse out 1: one-cycle strobes on accepted start/end marker.
REQ-017 Port rd_cycles out CNT_W: combinational read of result[rd_idx]; 0 when rd_idx >= N_TESTS.

Function
REQ-018 Marker encoding: start(i) = {PREFIX, i[3:0], 4'h0}; end(i) = {PREFIX, i[3:0], 4'h1}.
REQ-019 Acceptance: word W accepted on the cycle its consecutive-hold count reaches STABLE_CYC and W differs from last accepted word; each distinct word accepted once.
REQ-020 Latency: W present on checkbits cycles t..t+STABLE_CYC-1 -> corresponding pulse high at cycle t+STABLE_CYC, for exactly one cycle.
REQ-021 Words whose top DATA_W-8 bits differ from PREFIX are never accepted and never cause failure; they do reset the hold count.
REQ-022 FSM states IDLE, WAIT_START, RUN, PASS, FAIL.
REQ-023 IDLE -> WAIT_START when enable high; cur_test=0, timeout counter cleared, results cleared, last-accepted word cleared.
REQ-024 WAIT_START: accepted start(cur_test) -> RUN, start_pulse, test cycle counter cleared to 0.
REQ-025 RUN: test counter increments every cycle, saturating at all-ones.
REQ-026 RUN: accepted end(cur_test) -> end_pulse, result[cur_test] = counter value (cycles from start_pulse to end_pulse); last test -> PASS, else cur_test+1 and WAIT_START.
REQ-027 Any other accepted marker in WAIT_START/RUN -> FAIL, fail_code 2.
REQ-028 Timeout counter increments in WAIT_START/RUN; reaching TIMEOUT_CYC -> FAIL, fail_code 1.
REQ-029 Same-cycle timeout and valid marker: marker processed, timeout ignored that cycle; if marker completes the sequence, PASS.
REQ-030 PASS/FAIL hold, with results readable, until enable low -> IDLE; enable low in any state -> IDLE next cycle.
REQ-031 pass and fail never high together; busy low in IDLE/PASS/FAIL.

Reset
REQ-032 resetb low: immediately IDLE; busy, pass, fail, pulses 0; fail_code 0; cur_test 0; all results, counters, hold state 0; mid-test reset discards progress.

Verification
REQ-033 Defaults, enable=1, drive AB00, hold 10 cycles, AB01, then AB10/AB11, AB20/AB21 -> three start/end pulse pairs, pass=1, rd_idx=0 reads 10+... exact start-to-end count, fail=0.
REQ-034 Glitch: AB00 held 1 cycle then 0000 -> no start_pulse; AB00 held 2 cycles -> start_pulse at cycle 2 after first appearance.
REQ-035 Order: after AB00 accepted, drive AB11 for 2 cycles -> fail=1, fail_code=2, busy=0.
REQ-036 Timeout: TIMEOUT_CYC=50, enable, hold AB00 only -> fail=1, fail_code=1 at cycle 50; end marker landing on cycle 50 on last test -> pass=1.
REQ-037 Reset mid-RUN (cur_test=1): resetb low 1 cycle -> all outputs 0, rd_cycles 0 for all rd_idx; re-enable restarts at test 0.
REQ-038 Non-prefix words (1234, FFFF) between markers -> ignored; rd_idx=5 -> rd_cycles=0.

Source files
------------

// File: rtl/checkpoint_monitor_if.sv
// checkpoint_monitor_if: control, progress-word and result signals of the checkpoint monitor.
interface checkpoint_monitor_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
);
  logic              enable;
  logic [DATA_W-1:0] checkbits;
  logic [3:0]        rd_idx;
  logic              busy;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_code;
  logic [3:0]        cur_test;
  logic              start_pulse;
  logic              end_pulse;
  logic [CNT_W-1:0]  rd_cycles;
  modport master (
    output enable, checkbits, rd_idx,
    input  busy, pass, fail, fail_code, cur_test, start_pulse, end_pulse, rd_cycles
  );
  modport slave (
    input  enable, checkbits, rd_idx,
    output busy, pass, fail, fail_code, cur_test, start_pulse, end_pulse, rd_cycles
  );
endinterface

// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor: debounces firmware progress words and times an ordered start/end test sequence.
module checkpoint_monitor #(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-9:0] PREFIX      = 'hAB,
  parameter int                N_TESTS     = 3,
  parameter int                STABLE_CYC  = 2,
  parameter int                TIMEOUT_CYC = 100000,
  parameter int                CNT_W       = 32
) (
  input logic                 clock,
  input logic                 resetb,
  checkpoint_monitor_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, WAIT_START, RUN, PASS, FAIL} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d, last_q, last_d, w;
  logic [4:0]        hold_q, hold_d;
  logic [3:0]        cur_test_q, cur_test_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  res_q [16];
  logic [CNT_W-1:0]  res_d [16];
  logic [1:0]        code_q, code_d;
  logic              sp_q, sp_d, ep_q, ep_d;
  logic              active, accept, is_start, is_end, timed_out, last_test;
  always_comb begin
    w         = bus.checkbits;
    prev_d    = w;
    hold_d    = (w != prev_q) ? 5'd1 : (hold_q == 5'(STABLE_CYC)) ? hold_q : hold_q + 5'd1;
    active    = (state_q == WAIT_START) || (state_q == RUN);
    accept    = active && (hold_d == 5'(STABLE_CYC)) && (w[DATA_W-1:8] == PREFIX) && (w != last_q);
    is_start  = w == {PREFIX, cur_test_q, 4'h0};
    is_end    = w == {PREFIX, cur_test_q, 4'h1};
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    timed_out = tmo_q >= TW'(TIMEOUT_CYC - 1);
    last_test = cur_test_q == 4'(N_TESTS - 1);
    state_d    = state_q;
    last_d     = last_q;
    cur_test_d = cur_test_q;
    tmo_d      = (active && tmo_q != TW'(TIMEOUT_CYC)) ? tmo_q + TW'(1) : tmo_q;
    cnt_d      = (state_q == RUN) ? cnt_inc : cnt_q;
    res_d      = res_q;
    code_d     = code_q;
    sp_d       = 1'b0;
    ep_d       = 1'b0;
    if (!bus.enable) begin
      state_d    = IDLE;
      cur_test_d = 4'd0;
      code_d     = 2'd0;
    end else if (state_q == IDLE) begin
      state_d    = WAIT_START;
      cur_test_d = 4'd0;
      tmo_d      = '0;
      res_d      = '{default: '0};
      last_d     = '0;
      code_d     = 2'd0;
    end else if (accept) begin
      // an in-order marker wins over a timeout landing on the same cycle
      last_d = w;
      if (state_q == WAIT_START && is_start) begin
        state_d = RUN;
        sp_d    = 1'b1;
        cnt_d   = '0;
      end else if (state_q == RUN && is_end) begin
        ep_d               = 1'b1;
        res_d[cur_test_q]  = cnt_inc;
        state_d            = last_test ? PASS : WAIT_START;
        cur_test_d         = last_test ? cur_test_q : cur_test_q + 4'd1;
      end else begin
        state_d = FAIL;
        code_d  = 2'd2;
      end
    end else if (active && timed_out) begin
      state_d = FAIL;
      code_d  = 2'd1;
    end
  end
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      last_q     <= '0;
      hold_q     <= '0;
      cur_test_q <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '{default: '0};
      code_q     <= '0;
      sp_q       <= 1'b0;
      ep_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      cur_test_q <= cur_test_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      code_q     <= code_d;
      sp_q       <= sp_d;
      ep_q       <= ep_d;
    end
  end
  assign bus.busy        = (state_q == WAIT_START) || (state_q == RUN);
  assign bus.pass        = state_q == PASS;
  assign bus.fail        = state_q == FAIL;
  assign bus.fail_code   = code_q;
  assign bus.cur_test    = cur_test_q;
  assign bus.start_pulse = sp_q;
  assign bus.end_pulse   = ep_q;
  assign bus.rd_cycles   = (bus.rd_idx < 4'(N_TESTS)) ? res_q[bus.rd_idx] : '0;
endmodule

// File: tb/tb_checkpoint_monitor.sv
// tb_checkpoint_monitor: directed checks of the checkpoint monitor (default and short-timeout instances).
module tb_checkpoint_monitor;
  logic clock = 1'b0;
  logic resetb;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sp_n = 0;
  int   ep_n = 0;
  checkpoint_monitor_if #(.DATA_W(16), .CNT_W(32)) ia ();
  checkpoint_monitor_if #(.DATA_W(16), .CNT_W(32)) ib ();
  checkpoint_monitor u_a (.clock(clock), .resetb(resetb), .bus(ia.slave));
  checkpoint_monitor #(.TIMEOUT_CYC(50)) u_b (.clock(clock), .resetb(resetb), .bus(ib.slave));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    sp_n += int'(ia.start_pulse);
    ep_n += int'(ia.end_pulse);
  endtask
  task automatic drive(input logic [15:0] v);
    ia.checkbits = v;
    ib.checkbits = v;
  endtask
  task automatic hold(input logic [15:0] v, input int n);
    drive(v);
    repeat (n) step();
  endtask
  task automatic rd(input logic [3:0] idx);
    ia.rd_idx = idx;
    ib.rd_idx = idx;
    #1;
  endtask
  initial begin
    resetb = 1'b0;
    ia.enable = 1'b0;
    ib.enable = 1'b0;
    drive(16'h0);
    rd(4'd0);
    step();
    check("rst_busy", ia.busy, 0);
    check("rst_pass", ia.pass, 0);
    check("rst_fail", ia.fail, 0);
    check("rst_code", ia.fail_code, 0);
    check("rst_cur", ia.cur_test, 0);
    check("rst_sp", ia.start_pulse, 0);
    check("rst_rd", ia.rd_cycles, 0);
    step();
    resetb = 1'b1;
    // full in-order sequence with non-prefix noise between markers
    ia.enable = 1'b1;
    step();
    check("arm_busy", ia.busy, 1);
    sp_n = 0;
    ep_n = 0;
    hold(16'hAB00, 10);
    check("t0_sp", sp_n, 1);
    check("t0_ep", ep_n, 0);
    hold(16'hAB01, 2);
    check("t0_end", ep_n, 1);
    check("t0_cur", ia.cur_test, 1);
    rd(4'd0);
    check("t0_rd", ia.rd_cycles, 10);
    hold(16'hAB10, 3);
    hold(16'h1234, 2);
    hold(16'hFFFF, 2);
    check("noise_fail", ia.fail, 0);
    check("noise_busy", ia.busy, 1);
    hold(16'hAB11, 2);
    check("t1_end", ep_n, 2);
    hold(16'hAB20, 2);
    hold(16'hAB21, 2);
    check("seq_pass", ia.pass, 1);
    check("seq_fail", ia.fail, 0);
    check("seq_busy", ia.busy, 0);
    check("seq_code", ia.fail_code, 0);
    check("seq_sp", sp_n, 3);
    check("seq_ep", ep_n, 3);
    rd(4'd0);
    check("rd0", ia.rd_cycles, 10);
    rd(4'd1);
    check("rd1", ia.rd_cycles, 7);
    rd(4'd2);
    check("rd2", ia.rd_cycles, 2);
    rd(4'd5);
    check("rd5", ia.rd_cycles, 0);
    hold(16'hAB21, 3);
    check("pass_hold", ia.pass, 1);
    check("pass_no_reacc", ep_n, 3);
    ia.enable = 1'b0;
    step();
    check("idle_pass", ia.pass, 0);
    check("idle_busy", ia.busy, 0);
    // one-cycle glitch is rejected; two-cycle hold is accepted
    drive(16'h0);
    ia.enable = 1'b1;
    step();
    sp_n = 0;
    hold(16'hAB00, 1);
    hold(16'h0000, 3);
    check("glitch_sp", sp_n, 0);
    drive(16'hAB00);
    step();
    check("stable_c1", ia.start_pulse, 0);
    step();
    check("stable_c2", ia.start_pulse, 1);
    // out-of-order end marker
    hold(16'hAB11, 1);
    check("order_pre", ia.fail, 0);
    step();
    check("order_fail", ia.fail, 1);
    check("order_code", ia.fail_code, 2);
    check("order_busy", ia.busy, 0);
    check("order_pass", ia.pass, 0);
    // reset in the middle of test 1
    ia.enable = 1'b0;
    step();
    drive(16'h0);
    ia.enable = 1'b1;
    step();
    hold(16'hAB00, 2);
    hold(16'hAB01, 2);
    hold(16'hAB10, 2);
    check("mid_busy", ia.busy, 1);
    check("mid_cur", ia.cur_test, 1);
    check("mid_sp", ia.start_pulse, 1);
    rd(4'd0);
    check("mid_rd0", ia.rd_cycles, 2);
    resetb = 1'b0;
    #1;
    check("mrst_busy", ia.busy, 0);
    check("mrst_cur", ia.cur_test, 0);
    check("mrst_sp", ia.start_pulse, 0);
    check("mrst_rd0", ia.rd_cycles, 0);
    drive(16'h0);
    step();
    rd(4'd1);
    check("mrst_rd1", ia.rd_cycles, 0);
    rd(4'd2);
    check("mrst_rd2", ia.rd_cycles, 0);
    resetb = 1'b1;
    step();
    check("rearm_busy", ia.busy, 1);
    check("rearm_cur", ia.cur_test, 0);
    hold(16'hAB00, 2);
    check("rearm_sp", ia.start_pulse, 1);
    check("rearm_cur0", ia.cur_test, 0);
    // timeout after 50 armed cycles
    ia.enable = 1'b0;
    drive(16'hAB00);
    ib.enable = 1'b1;
    step();
    repeat (49) step();
    check("tmo_pre", ib.fail, 0);
    check("tmo_pre_busy", ib.busy, 1);
    step();
    check("tmo_fail", ib.fail, 1);
    check("tmo_code", ib.fail_code, 1);
    check("tmo_busy", ib.busy, 0);
    // final end marker accepted on the deadline cycle
    ib.enable = 1'b0;
    step();
    drive(16'h0);
    ib.enable = 1'b1;
    step();
    hold(16'hAB00, 2);
    hold(16'hAB01, 2);
    hold(16'hAB10, 2);
    hold(16'hAB11, 2);
    hold(16'hAB20, 2);
    hold(16'h0000, 38);
    hold(16'hAB21, 1);
    check("dl_pre", ib.pass, 0);
    check("dl_pre_busy", ib.busy, 1);
    step();
    check("dl_pass", ib.pass, 1);
    check("dl_fail", ib.fail, 0);
    check("dl_ep", ib.end_pulse, 1);
    rd(4'd2);
    check("dl_rd2", ib.rd_cycles, 40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
